// File: rtl/simple_io_if.sv
// simple_io_if: request/response and external channel signals of simple_io_unit
interface simple_io_if;
  logic        io_in_req;
  logic        io_out_req;
  logic [15:0] out_wdata;
  logic [15:0] in_rdata;
  logic        io_busy;
  logic        io_done;
  logic        in_timeout;
  logic [15:0] ext_in_data;
  logic        ext_in_valid;
  logic        ext_in_ready;
  logic [15:0] ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ready;
  modport master (
    output io_in_req, io_out_req, out_wdata, ext_in_data, ext_in_valid, ext_out_ready,
    input  in_rdata, io_busy, io_done, in_timeout, ext_in_ready, ext_out_data, ext_out_valid
  );
  modport slave (
    input  io_in_req, io_out_req, out_wdata, ext_in_data, ext_in_valid, ext_out_ready,
    output in_rdata, io_busy, io_done, in_timeout, ext_in_ready, ext_out_data, ext_out_valid
  );
endinterface

// File: rtl/simple_io_unit.sv
// simple_io_unit: IN/OUT sequencer with an output FIFO and an IN timeout
module simple_io_unit #(
  parameter int OUT_DEPTH  = 4,
  parameter int IN_TIMEOUT = 1024
) (
  input logic       clk,
  input logic       rst,
  simple_io_if.slave io
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int TW = IN_TIMEOUT > 1 ? $clog2(IN_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(IN_TIMEOUT > 0 ? IN_TIMEOUT - 1 : 0);
  localparam logic [AW:0] FULL = (AW+1)'(OUT_DEPTH);
  typedef enum logic [1:0] {IDLE, IN_WAIT, OUT_WAIT} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   pend_q, pend_d, rdata_q, rdata_d, push_data;
  logic          done_q, done_d, to_q, to_d, push, pop, full, valid;
  logic [15:0]   mem_q [OUT_DEPTH];
  assign full  = cnt_q == FULL;
  assign valid = cnt_q != '0;
  assign pop   = valid && io.ext_out_ready;
  // Push decisions look only at the registered count, so a same-cycle pop never makes room
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    rdata_d   = rdata_q;
    to_d      = to_q;
    tmo_d     = tmo_q;
    done_d    = 1'b0;
    push      = 1'b0;
    push_data = io.out_wdata;
    case (state_q)
      IDLE: begin
        if (io.io_out_req) begin
          if (!full) begin
            push   = 1'b1;
            done_d = 1'b1;
          end else begin
            pend_d  = io.out_wdata;
            state_d = OUT_WAIT;
          end
        end else if (io.io_in_req) begin
          tmo_d   = '0;
          state_d = IN_WAIT;
        end
      end
      OUT_WAIT: begin
        if (!full) begin
          push      = 1'b1;
          push_data = pend_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      IN_WAIT: begin
        if (io.ext_in_valid) begin
          rdata_d = io.ext_in_data;
          to_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (IN_TIMEOUT != 0 && tmo_q == TMO_LAST) begin
          rdata_d = '0;
          to_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    wp_d  = wp_q + AW'(push);
    rp_d  = rp_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      pend_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= push_data;
  end
  assign io.in_rdata      = rdata_q;
  assign io.io_busy       = state_q != IDLE;
  assign io.io_done       = done_q;
  assign io.in_timeout    = to_q;
  assign io.ext_in_ready  = state_q == IN_WAIT;
  assign io.ext_out_valid = valid;
  assign io.ext_out_data  = valid ? mem_q[rp_q] : '0;
endmodule

// File: tb/tb_simple_io_unit.sv
// tb_simple_io_unit: directed vector table plus reset corner sequence for simple_io_unit
module tb_simple_io_unit;
  typedef struct {
    logic        ir, orq;
    logic [15:0] wd;
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        done, busy, irdy, ov;
    logic [15:0] od, rd;
    logic        to;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t vq[$];
  simple_io_if bus();
  simple_io_unit #(.OUT_DEPTH(4), .IN_TIMEOUT(8)) dut (.clk(clk), .rst(rst), .io(bus));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic ir, logic orq, logic [15:0] wd, logic iv, logic [15:0] id,
                              logic ordy, logic done, logic busy, logic irdy, logic ov,
                              logic [15:0] od, logic [15:0] rd, logic to);
    vec_t v;
    v.ir = ir; v.orq = orq; v.wd = wd; v.iv = iv; v.id = id; v.ordy = ordy;
    v.done = done; v.busy = busy; v.irdy = irdy; v.ov = ov; v.od = od; v.rd = rd; v.to = to;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_out(input string tag, input vec_t v);
    chk({tag, ".io_done"}, 16'(bus.io_done), 16'(v.done));
    chk({tag, ".io_busy"}, 16'(bus.io_busy), 16'(v.busy));
    chk({tag, ".ext_in_ready"}, 16'(bus.ext_in_ready), 16'(v.irdy));
    chk({tag, ".ext_out_valid"}, 16'(bus.ext_out_valid), 16'(v.ov));
    chk({tag, ".ext_out_data"}, bus.ext_out_data, v.od);
    chk({tag, ".in_rdata"}, bus.in_rdata, v.rd);
    chk({tag, ".in_timeout"}, 16'(bus.in_timeout), 16'(v.to));
  endtask
  task automatic drive(input vec_t v);
    bus.io_in_req     = v.ir;
    bus.io_out_req    = v.orq;
    bus.out_wdata     = v.wd;
    bus.ext_in_valid  = v.iv;
    bus.ext_in_data   = v.id;
    bus.ext_out_ready = v.ordy;
  endtask
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    chk_out(tag, v);
  endtask
  initial begin
    vec_t z;
    z = mk(0,0,0,0,0,0, 0,0,0,0,0,0,0);
    drive(z);
    #1;
    chk_out("reset", z);
    // single OUT with a ready consumer
    vq.push_back(mk(0,1,16'h1234,0,0,1, 1,0,0,1,16'h1234,0,0));
    vq.push_back(mk(0,0,0,0,0,1,        0,0,0,0,0,0,0));
    // fill FIFO with ready low, fifth OUT stalls
    for (int k = 0; k < 4; k++) begin
      vq.push_back(mk(0,1,16'hA001 + 16'(k),0,0,0, 1,0,0,1,16'hA001,0,0));
      vq.push_back(mk(0,0,0,0,0,0,                 0,0,0,1,16'hA001,0,0));
    end
    vq.push_back(mk(0,1,16'hA005,0,0,0, 0,1,0,1,16'hA001,0,0));
    vq.push_back(mk(1,1,16'hDEAD,0,0,0, 0,1,0,1,16'hA001,0,0));
    vq.push_back(mk(0,0,0,0,0,1,        0,1,0,1,16'hA002,0,0));
    vq.push_back(mk(0,0,0,0,0,0,        1,0,0,1,16'hA002,0,0));
    vq.push_back(mk(0,0,0,0,0,1,        0,0,0,1,16'hA003,0,0));
    vq.push_back(mk(0,0,0,0,0,1,        0,0,0,1,16'hA004,0,0));
    vq.push_back(mk(0,0,0,0,0,1,        0,0,0,1,16'hA005,0,0));
    vq.push_back(mk(0,0,0,0,0,1,        0,0,0,0,0,0,0));
    // simultaneous IN and OUT: OUT wins
    vq.push_back(mk(1,1,16'h5555,0,0,0, 1,0,0,1,16'h5555,0,0));
    vq.push_back(mk(0,0,0,0,0,0,        0,0,0,1,16'h5555,0,0));
    vq.push_back(mk(0,0,0,0,0,1,        0,0,0,0,0,0,0));
    // IN with data three cycles after the request
    vq.push_back(mk(1,0,0,0,0,0,          0,1,1,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,          0,1,1,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,          0,1,1,0,0,0,0));
    vq.push_back(mk(0,0,0,1,16'hBEEF,0,   1,0,0,0,0,16'hBEEF,0));
    vq.push_back(mk(0,0,0,1,16'h1111,0,   0,0,0,0,0,16'hBEEF,0));
    // timeout after 8 IN_WAIT cycles, then a successful IN clears the flag
    vq.push_back(mk(1,0,0,0,0,0, 0,1,1,0,0,16'hBEEF,0));
    for (int k = 0; k < 7; k++) vq.push_back(mk(0,0,0,0,0,0, 0,1,1,0,0,16'hBEEF,0));
    vq.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,1));
    vq.push_back(mk(1,0,0,0,0,0, 0,1,1,0,0,0,1));
    vq.push_back(mk(0,0,0,1,16'hCAFE,0, 1,0,0,0,0,16'hCAFE,0));
    // handshake on the expiry cycle wins
    vq.push_back(mk(1,0,0,0,0,0, 0,1,1,0,0,16'hCAFE,0));
    for (int k = 0; k < 7; k++) vq.push_back(mk(0,0,0,0,0,0, 0,1,1,0,0,16'hCAFE,0));
    vq.push_back(mk(0,0,0,1,16'h7777,0, 1,0,0,0,0,16'h7777,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    foreach (vq[i]) apply($sformatf("v%0d", i), vq[i]);
    // reset during IN_WAIT with two buffered words
    apply("r0", mk(0,1,16'h0101,0,0,0, 1,0,0,1,16'h0101,16'h7777,0));
    apply("r1", mk(0,1,16'h0202,0,0,0, 1,0,0,1,16'h0101,16'h7777,0));
    apply("r2", mk(1,0,0,0,0,0,        0,1,1,1,16'h0101,16'h7777,0));
    @(negedge clk);
    rst = 1'b0;
    drive(z);
    #1;
    chk_out("rst_async", z);
    repeat (2) @(posedge clk);
    #1;
    chk_out("rst_hold", z);
    @(negedge clk);
    rst = 1'b1;
    drive(mk(0,1,16'h4242,0,0,0, 0,0,0,0,0,0,0));
    #1;
    chk_out("rst_release", z);
    @(posedge clk);
    #1;
    chk_out("first_edge", mk(0,1,16'h4242,0,0,0, 1,0,0,1,16'h4242,0,0));
    apply("after", mk(0,0,0,0,0,1, 0,0,0,0,0,0,0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/simple_io_unit.md
SIMPLE_IO_UNIT -- requirements
Module: simple_io_unit

Interface
REQ-001 Parameter OUT_DEPTH, default 4, meaning output FIFO depth in words; it SHALL be a power of 2 and at least 2.
REQ-002 Parameter IN_TIMEOUT, default 1024, meaning maximum IN_WAIT cycles before abort; a value of 0 SHALL disable the timeout.
REQ-003 Port clk, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port io_in_req, input, 1 bit: single-cycle IN request from the control unit (P4).
REQ-006 Port io_out_req, input, 1 bit: single-cycle OUT request from the control unit (P4).
REQ-007 Port out_wdata, input, 16 bits: r[Ra] value to output, sampled with io_out_req.
REQ-008 Port in_rdata, output, 16 bits: registered IN result, written to r[Ra] in P5.
REQ-009 Port io_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 Port io_done, output, 1 bit: registered completion pulse, high exactly 1 cycle per accepted request.
REQ-011 Port in_timeout, output, 1 bit: sticky flag meaning the last IN aborted.
REQ-012 Ports ext_in_data (input, 16 bits), ext_in_valid (input, 1 bit) and ext_in_ready (output, 1 bit): external input channel.
REQ-013 Ports ext_out_data (output, 16 bits), ext_out_valid (output, 1 bit) and ext_out_ready (input, 1 bit): external output channel.

Function
REQ-014 The FSM SHALL have the states IDLE, IN_WAIT and OUT_WAIT; io_done SHALL be a registered side output, not a state.
REQ-015 Requests SHALL be sampled only in IDLE; requests arriving in any other state SHALL be ignored and produce no io_done.
REQ-016 If io_in_req and io_out_req are high together in IDLE, OUT SHALL be served and IN SHALL be dropped.
REQ-017 OUT in IDLE with registered count < OUT_DEPTH: push out_wdata at edge T, pulse io_done in cycle T+1, and stay in IDLE.
REQ-018 OUT in IDLE with the FIFO full: latch out_wdata and go to OUT_WAIT.
- In OUT_WAIT, push on the first edge where registered count < OUT_DEPTH, pulse io_done the next cycle, then return to IDLE.
REQ-019 A pop in the same cycle does not free space for a push that cycle: the push decision SHALL use the registered count only, giving a 1-cycle bubble.
REQ-020 The FIFO SHALL drain independently of the FSM.
- ext_out_valid = (count != 0); ext_out_data = head word.
- Pop on ext_out_valid & ext_out_ready.
- ext_out_data SHALL be held stable while ext_out_valid is high and ext_out_ready is low.
REQ-021 Pointers SHALL wrap modulo OUT_DEPTH; count SHALL span 0..OUT_DEPTH inclusive; order SHALL be first-in first-out.
REQ-022 IN: io_in_req in IDLE → go to IN_WAIT; ext_in_ready SHALL be high in every IN_WAIT cycle and low otherwise.
REQ-023 An IN_WAIT cycle with ext_in_valid high: in_rdata <= ext_in_data, in_timeout <= 0, io_done pulses the next cycle, return to IDLE.
REQ-024 Timeout counter behaviour:
- Cleared on entering IN_WAIT; incremented each IN_WAIT cycle without a handshake.
- If it equals IN_TIMEOUT-1 with no handshake that cycle: in_rdata <= 0, in_timeout <= 1, io_done pulses, return to IDLE.
- IN_WAIT therefore lasts at most IN_TIMEOUT cycles.
REQ-025 A handshake in the same cycle as timeout expiry SHALL win: the data is captured and in_timeout is cleared.
REQ-026 in_rdata SHALL change only on IN completion and SHALL otherwise hold its value.
REQ-027 A pending OUT in OUT_WAIT SHALL complete only via FIFO space; it has no timeout.

Reset
REQ-028 On rst low, asynchronously:
- state = IDLE; FIFO empty; pointers and counters = 0.
- in_rdata = 0x0000; io_done, io_busy, in_timeout, ext_in_ready, ext_out_valid = 0; ext_out_data = 0x0000.
REQ-029 A reset during IN_WAIT or OUT_WAIT SHALL discard the pending request without an io_done pulse; buffered OUT words SHALL be lost.
REQ-030 After rst deasserts, the first rising edge SHALL accept requests normally.

Verification
REQ-031 OUT 0x1234 with ext_out_ready=1 → io_done at T+1; ext_out_valid/ext_out_data=0x1234 at T+1; popped at that edge.
REQ-032 Five OUTs 0xA001..0xA005 spaced 2 cycles apart, ext_out_ready=0 → first four get io_done; fifth leaves io_busy=1. Then ext_out_ready=1 for 1 cycle → 0xA001 popped; fifth pushed the following edge, io_done one cycle later; drain order A002..A005.
REQ-033 IN with ext_in_valid=1 and data 0xBEEF arriving 3 cycles after the request → ext_in_ready high from T+1; in_rdata=0xBEEF; io_done 1 cycle after the handshake; in_timeout=0.
REQ-034 IN_TIMEOUT=8 with no valid → io_done after exactly 8 IN_WAIT cycles; in_rdata=0x0000; in_timeout=1. A following successful IN clears in_timeout.
REQ-035 io_in_req and io_out_req together with 0x5555 → only 0x5555 pushed; ext_in_ready never rises; one io_done.
REQ-036 rst low during IN_WAIT with 2 FIFO words → all outputs at reset values; no io_done; ext_out_valid=0 after release.
